// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the 4-digit 7-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t GLYPH_0     = 7'h40;
  localparam seg7_t GLYPH_1     = 7'h79;
  localparam seg7_t GLYPH_2     = 7'h24;
  localparam seg7_t GLYPH_3     = 7'h30;
  localparam seg7_t GLYPH_4     = 7'h19;
  localparam seg7_t GLYPH_5     = 7'h12;
  localparam seg7_t GLYPH_6     = 7'h02;
  localparam seg7_t GLYPH_7     = 7'h78;
  localparam seg7_t GLYPH_8     = 7'h00;
  localparam seg7_t GLYPH_9     = 7'h10;
  localparam seg7_t GLYPH_A     = 7'h08;
  localparam seg7_t GLYPH_B     = 7'h03;
  localparam seg7_t GLYPH_C     = 7'h46;
  localparam seg7_t GLYPH_D     = 7'h21;
  localparam seg7_t GLYPH_E     = 7'h06;
  localparam seg7_t GLYPH_F     = 7'h0E;
  localparam seg7_t GLYPH_BLANK = 7'h7F;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
  } disp_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Nibble to active-low glyph decoder.
// SEG7_SCAN_HEX_EN adds A-F glyphs; otherwise 10-15 are blank.
import seg7_pkg::*;

module seg7_glyph_decode (
  input  logic [3:0] nibble,
  output seg7_t      glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
`ifdef SEG7_SCAN_HEX_EN
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
`endif
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Optional hex glyphs via SEG7_SCAN_HEX_EN (see seg7_glyph_decode).
import seg7_pkg::*;

module seg7_scan_mux #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic                    frame_o,
  output logic [NUM_DIGITS-1:0]   an,
  output seg7_t                   seg,
  output logic                    dp
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  if (DIV <= BLANK_CYCLES + 1) begin : g_bad_div
    $error("seg7_scan_mux: DIV must exceed BLANK_CYCLES+1");
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  disp_t         act;
  disp_t         pend;
  phase_t        phase;
  seg7_t         glyph;
  logic          commit;

  assign commit  = (cnt == LAST) && (idx == 2'd3);
  assign frame_o = commit;
  assign phase   = (cnt < BLK) ? PH_BLANK : PH_SHOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the commit cycle wins the pending slot; the old one still commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act       <= '0;
      pend      <= '0;
      pending_o <= 1'b0;
    end else begin
      if (commit && pending_o)
        act <= pend;
      if (load_i) begin
        pend      <= '{value: value_i, dp: dp_i, en: digit_en_i};
        pending_o <= 1'b1;
      end else if (commit) begin
        pending_o <= 1'b0;
      end
    end
  end

  seg7_glyph_decode u_dec (
    .nibble (act.value[{idx, 2'b00} +: 4]),
    .glyph  (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= GLYPH_BLANK;
      dp  <= 1'b1;
    end else if (phase == PH_SHOW && act.en[idx]) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= glyph;
      dp  <= ~act.dp[idx];
    end else begin
      an  <= '1;
      seg <= GLYPH_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux against a frame-level display model.
// Honours SEG7_SCAN_HEX_EN the same way the design does.
module tb_seg7_scan_mux;

  localparam int DIVT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIVT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic        load_i = 1'b0;
  logic        pending_o;
  logic        frame_o;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;

  // model state: edges since reset release, shown and queued frames
  int          n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic [15:0] q_val = '0;
  logic [3:0]  q_dp = '0;
  logic [3:0]  q_en = '0;
  logic        q_v = 1'b0;

  seg7_scan_mux #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .digit_en_i (digit_en_i),
    .load_i     (load_i),
    .pending_o  (pending_o),
    .frame_o    (frame_o),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t n=%0d: got %h expected %h",
               tag, $time, n, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_SCAN_HEX_EN
    return tbl[d];
`else
    return (d > 4'd9) ? 7'h7F : tbl[d];
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    m_val = '0; m_dp = '0; m_en = '0;
    q_val = '0; q_dp = '0; q_en = '0;
    q_v = 1'b0;
  endtask

  task automatic cycle(input logic ld, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] e);
    logic [3:0] e_an;
    logic [3:0] one;
    logic [6:0] e_seg;
    logic       e_dp;
    int p;
    int dg;
    int c;
    @(negedge clk);
    rst_n = 1'b1;
    load_i = ld;
    value_i = v;
    dp_i = d;
    digit_en_i = e;
    p = n % FRAME;
    dg = p / DIVT;
    c = p % DIVT;
    e_an = 4'hF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
    if (c >= BLANK && m_en[dg]) begin
      one = 4'b0001 << dg;
      e_an = ~one;
      e_seg = ref_glyph(m_val[dg*4 +: 4]);
      e_dp = ~m_dp[dg];
    end
    if (p == FRAME - 1 && q_v) begin
      m_val = q_val; m_dp = q_dp; m_en = q_en;
      q_v = 1'b0;
    end
    if (ld) begin
      q_val = v; q_dp = d; q_en = e;
      q_v = 1'b1;
    end
    n++;
    @(posedge clk);
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("pending", 16'(pending_o), 16'(q_v));
    chk("frame", 16'(frame_o), 16'((n % FRAME) == FRAME - 1));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, '0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) idle(1);
  endtask

  initial begin
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_pending", 16'(pending_o), 16'h0);
    chk("rst_frame", 16'(frame_o), 16'h0);

    idle(12);
    cycle(1'b1, 16'h1234, 4'h0, 4'hF);
    idle(90);

    run_to(15);
    cycle(1'b1, 16'h5678, 4'h0, 4'hF);
    idle(60);

    run_to(10);
    cycle(1'b1, 16'h9999, 4'hF, 4'hF);
    run_to(FRAME - 1);
    cycle(1'b1, 16'h0000, 4'h0, 4'hF);
    idle(FRAME + 10);

    cycle(1'b1, 16'hABCD, 4'b0001, 4'b0101);
    idle(2 * FRAME);

    cycle(1'b1, 16'h4321, 4'h0, 4'hF);
    run_to(25);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", 16'(an), 16'hF);
    chk("async_seg", 16'(seg), 16'h7F);
    chk("async_dp", 16'(dp), 16'h1);
    chk("async_pending", 16'(pending_o), 16'h0);
    model_reset();
    idle(2 * FRAME);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 11) == 0)
        cycle(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
